// File: rtl/kgp_arb_defs.sv
// Shared definitions for the KGPminiRISC memory-port arbiter:
// sequencer state encodings, port index constants and default sizing.
package kgp_arb_defs;

  // Sequencer state encodings; 2'd3 is unused and recovers to ST_IDLE.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Requester indices as seen on sel.
  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

  // Default sizing of the GRANT timeout.
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser. A lone requester always wins; under
// contention the port that did not win last time is picked.
module rr_pick2
  import kgp_arb_defs::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  // Pure combinational pick, no state of its own.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last;
    end else if (req1) begin
      grant_idx = PORT_LSU;
    end else begin
      grant_idx = PORT_IFETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single 32-bit memory port between instruction fetch (port 0)
// and the load/store unit (port 1). One access in flight at a time,
// sequenced IDLE -> GRANT -> DONE, round-robin between the ports.
module mem_port_arbiter
  import kgp_arb_defs::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        sel,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             sel_reg;
  logic             last_reg;
  logic [1:0]       done_reg;
  logic [31:0]      rdata_reg;
  logic             err_reg;

  logic grant_valid;
  logic grant_idx;
  logic timeout_hit;
  logic in_grant;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last        (last_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign in_grant    = (state_reg == ST_GRANT);
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Operands come straight from the granted port; the requester holds them
  // stable for the whole GRANT phase, so nothing is latched here.
  assign mem_valid = in_grant;
  assign mem_we    = in_grant & (sel_reg ? we1 : we0);
  assign mem_addr  = sel_reg ? addr1  : addr0;
  assign mem_wdata = sel_reg ? wdata1 : wdata0;

  assign sel   = sel_reg;
  assign done0 = done_reg[0];
  assign done1 = done_reg[1];
  assign rdata = rdata_reg;
  assign err   = err_reg;

  // Next-state decode; mem_ready takes priority over an expiring timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (grant_valid) state_next = ST_GRANT;
      ST_GRANT: if (mem_ready || timeout_hit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping and the registered requester-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sel_reg   <= PORT_IFETCH;
      last_reg  <= PORT_LSU;
      cnt_reg   <= '0;
      done_reg  <= 2'b00;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 2'b00;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            sel_reg <= grant_idx;
            cnt_reg <= '0;
          end
        end
        ST_GRANT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem_ready) begin
            rdata_reg         <= mem_rdata;
            err_reg           <= 1'b0;
            done_reg[sel_reg] <= 1'b1;
          end else if (timeout_hit) begin
            rdata_reg         <= 32'd0;
            err_reg           <= 1'b1;
            done_reg[sel_reg] <= 1'b1;
          end
        end
        ST_DONE: begin
          last_reg <= sel_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
